llr_stream_tx: RTL and testbench
================================

# llr_stream_tx

Transmit side of the decoder's LLR load protocol. The block accepts one complete frame of N_V channel LLRs in parallel and streams it to the decoder's chunked input as N_LLRS LLRs per beat, asserting `first_data` on the first beat and `data_valid` on every beat. It is placed upstream of the decoder top level, in the testbench harness and the channel front-end. It does not start a frame until the decoder reports not busy, and it never inserts gaps inside a frame.

## Interface
- WIDTH_IN, 8, bits per LLR
- N_LLRS, 4, LLRs per beat
- N_V, 31, LLRs per frame (variable nodes)
- clk  in  1  rising-edge clock; the block uses this single clock only
- rst  in  1  asynchronous, active-low reset
- frame_llrs  in  WIDTH_IN*N_V  frame; LLR k occupies bits [k*WIDTH_IN +: WIDTH_IN]
- frame_valid  in  1  frame_llrs is valid
- frame_ready  out  1  block can accept a frame; registered
- rx_busy  in  1  decoder busy flag; 0 means the decoder is idle and can start a frame
- databus_out  out  N_LLRS*WIDTH_IN  current beat
- first_data  out  1  beat 0 marker
- data_valid  out  1  databus_out is valid
- tx_done  out  1  one-cycle pulse after the last beat

## Operation
- Chunk geometry:
  - L_SEG = (N_V-1)/N_LLRS full beats.
  - LAST_N = (N_V-1)%N_LLRS + 1 LLRs in the final beat.
  - N_BEATS = L_SEG + 1.
- Beat ordering is MSB-first:
  - Beat b, for b < L_SEG, carries LLRs N_V-1-b*N_LLRS down to N_V-(b+1)*N_LLRS, with the highest LLR index in the top bits of databus_out.
  - The final beat carries LLRs LAST_N-1..0 right-aligned in the low bits. The unused upper bits are driven 0.
- States: IDLE, WAIT_RX, SEND, DONE.
- IDLE:
  - frame_ready=1.
  - frame_valid&&frame_ready captures frame_llrs into a shadow shift register. Next state is WAIT_RX.
- WAIT_RX:
  - frame_ready=0.
  - When rx_busy is sampled 0, register beat 0 with data_valid=1, first_data=1, and the beat counter set to 1. Next state is SEND.
- SEND:
  - One beat per cycle, with no backpressure.
  - The shadow register shifts left by N_LLRS*WIDTH_IN per beat.
  - first_data=0 after beat 0.
  - rx_busy is ignored in SEND.
  - When the final beat has been presented, the next edge clears data_valid and databus_out. Next state is DONE.
- DONE:
  - tx_done=1 for exactly one cycle.
  - Next state is IDLE with frame_ready=1.
- frame_valid outside IDLE is ignored. The frame is not queued.
- N_V <= N_LLRS is a degenerate case: N_BEATS=1, and the single beat carries first_data=1 and the partial-beat layout.
- Async reset, including mid-frame:
  - All outputs are cleared immediately to 0: frame_ready, databus_out, first_data, data_valid, tx_done.
  - The state returns to IDLE and the shadow register and counter clear.
  - frame_ready rises on the first clock edge after reset release.
  - A truncated frame is not resumed.

## Timing
- All outputs are registered.
- Frame accepted at edge T with rx_busy=0:
  - WAIT_RX is entered at T.
  - Beat 0 is valid after edge T+1.
  - Beat N_BEATS-1 is valid after edge T+N_BEATS.
  - data_valid falls and tx_done rises after edge T+N_BEATS+1.
  - frame_ready=1 after edge T+N_BEATS+2.
- If rx_busy stays 1, WAIT_RX holds indefinitely with data_valid=0.
- data_valid stays high for exactly N_BEATS consecutive cycles. first_data is high for exactly 1 cycle.
- Frame-to-frame throughput: N_BEATS+3 cycles minimum.

## Structure
- Shared header/package, so the decoder and the transmitter agree on frame geometry:
  - geometry localparams L_SEG, LLR_CHUNK=N_LLRS*WIDTH_IN, LAST_N, LAST_CHUNK=LAST_N*WIDTH_IN, N_BEATS
  - state encodings
- Counter width is $clog2(N_BEATS+1).
- The block is a single module. Chunk slicing and the shift register are inline; no sub-module is warranted.

## Test plan
All scenarios use defaults (8 beats, LAST_N=3) and a frame with LLR k = k.
- rx_busy=0, frame accepted:
  - beats are 0x1E1D1C1B, 0x1A191817, …, 0x06050403, 0x00020100
  - first_data only on 0x1E1D1C1B
  - data_valid high exactly 8 consecutive cycles
  - tx_done 1 cycle later
- rx_busy=1 for 10 cycles after accept: no data_valid while rx_busy=1. Beat 0 is valid 1 cycle after rx_busy is sampled 0.
- frame_valid pulsed with a different frame during SEND: it is ignored and the beat values are unchanged. frame_ready stays 0 until after the tx_done cycle.
- rst driven low after beat 3, asynchronously between edges: all outputs are 0 immediately. frame_ready=1 one edge after release, and a new frame then streams correctly from beat 0.
- Two back-to-back frames with frame_valid held high: the second beat 0 starts exactly N_BEATS+3 cycles after the first beat 0.
- Parameter sweep N_V=32 with N_LLRS=4 (LAST_N=4, last beat full), and N_V=3 with N_LLRS=4 (single beat 0x00020100 with first_data=1).

Source files
------------

// File: rtl/llr_stream_tx_pkg.sv
// Frame geometry and state encodings shared by the LLR transmitter and the decoder input stage.
// The helper functions let a parameterised instance derive the same geometry from its own N_V/N_LLRS.
package llr_stream_tx_pkg;

    localparam int DEF_WIDTH_IN = 8;
    localparam int DEF_N_LLRS   = 4;
    localparam int DEF_N_V      = 31;

    function automatic int calc_l_seg(input int n_v, input int n_llrs);
        return (n_v - 1) / n_llrs;
    endfunction

    function automatic int calc_last_n(input int n_v, input int n_llrs);
        return ((n_v - 1) % n_llrs) + 1;
    endfunction

    localparam int L_SEG      = calc_l_seg(DEF_N_V, DEF_N_LLRS);
    localparam int LLR_CHUNK  = DEF_N_LLRS * DEF_WIDTH_IN;
    localparam int LAST_N     = calc_last_n(DEF_N_V, DEF_N_LLRS);
    localparam int LAST_CHUNK = LAST_N * DEF_WIDTH_IN;
    localparam int N_BEATS    = L_SEG + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_RX = 2'd1;
    localparam logic [1:0] ST_SEND    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/llr_stream_tx.sv
// Streams one parallel frame of channel LLRs into the decoder's chunked input, MSB chunk first,
// waiting for the decoder to go idle and never inserting gaps inside a frame.
module llr_stream_tx
    import llr_stream_tx_pkg::*;
#(
    parameter int WIDTH_IN = 8,
    parameter int N_LLRS   = 4,
    parameter int N_V      = 31
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_IN*N_V-1:0]      frame_llrs,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    input  logic                         rx_busy,
    output logic [N_LLRS*WIDTH_IN-1:0]   databus_out,
    output logic                         first_data,
    output logic                         data_valid,
    output logic                         tx_done
);

    localparam int SEGS     = calc_l_seg(N_V, N_LLRS);
    localparam int TAIL_N   = calc_last_n(N_V, N_LLRS);
    localparam int CHUNK_W  = N_LLRS * WIDTH_IN;
    localparam int TAIL_W   = TAIL_N * WIDTH_IN;
    localparam int BEATS    = SEGS + 1;
    localparam int FRAME_W  = WIDTH_IN * N_V;
    localparam int SHADOW_W = BEATS * CHUNK_W;
    localparam int PAD_W    = SHADOW_W - FRAME_W;
    localparam int CNT_W    = $clog2(BEATS + 1);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SEGS);
    localparam logic [CNT_W-1:0] BEATS_CNT = CNT_W'(BEATS);

    logic [1:0]          state;
    logic [SHADOW_W-1:0] shadow;
    logic [CNT_W-1:0]    beat_cnt;
    logic [CNT_W-1:0]    beat_idx;
    logic [CHUNK_W-1:0]  next_beat;

    // The frame is parked left-justified in a whole number of chunks, so every beat is
    // the top of the shadow register and the short tail lands in the top TAIL_W bits.
    always_comb begin
        beat_idx  = (state == ST_SEND) ? beat_cnt : '0;
        next_beat = shadow[SHADOW_W-1 -: CHUNK_W];
        if (beat_idx == LAST_IDX) begin
            next_beat = CHUNK_W'(shadow[SHADOW_W-1 -: TAIL_W]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            beat_cnt    <= '0;
            frame_ready <= 1'b0;
            databus_out <= '0;
            first_data  <= 1'b0;
            data_valid  <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    frame_ready <= 1'b1;
                    if (frame_valid && frame_ready) begin
                        shadow      <= SHADOW_W'(frame_llrs) << PAD_W;
                        frame_ready <= 1'b0;
                        state       <= ST_WAIT_RX;
                    end
                end
                ST_WAIT_RX: begin
                    if (!rx_busy) begin
                        databus_out <= next_beat;
                        data_valid  <= 1'b1;
                        first_data  <= 1'b1;
                        beat_cnt    <= CNT_W'(1);
                        shadow      <= shadow << CHUNK_W;
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    first_data <= 1'b0;
                    if (beat_cnt == BEATS_CNT) begin
                        data_valid  <= 1'b0;
                        databus_out <= '0;
                        beat_cnt    <= '0;
                        tx_done     <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        databus_out <= next_beat;
                        shadow      <= shadow << CHUNK_W;
                        beat_cnt    <= beat_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    frame_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_llr_stream_tx.sv
// Self-checking bench for llr_stream_tx: spec vector table, hand-written corner sequences,
// and randomized frames compared against an index-arithmetic reference model.
module tb_llr_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         rx_busy;

    logic [247:0] frame_llrs;
    logic         frame_valid, frame_ready, first_data, data_valid, tx_done;
    logic [31:0]  databus_out;

    logic [255:0] frame_32;
    logic         valid_32, ready_32, first_32, dvalid_32, done_32;
    logic [31:0]  bus_32;

    logic [23:0]  frame_3;
    logic         valid_3, ready_3, first_3, dvalid_3, done_3;
    logic [31:0]  bus_3;

    llr_stream_tx dut (
        .clk(clk), .rst(rst), .frame_llrs(frame_llrs), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .rx_busy(rx_busy), .databus_out(databus_out),
        .first_data(first_data), .data_valid(data_valid), .tx_done(tx_done)
    );

    llr_stream_tx #(.WIDTH_IN(8), .N_LLRS(4), .N_V(32)) dut32 (
        .clk(clk), .rst(rst), .frame_llrs(frame_32), .frame_valid(valid_32),
        .frame_ready(ready_32), .rx_busy(rx_busy), .databus_out(bus_32),
        .first_data(first_32), .data_valid(dvalid_32), .tx_done(done_32)
    );

    llr_stream_tx #(.WIDTH_IN(8), .N_LLRS(4), .N_V(3)) dut3 (
        .clk(clk), .rst(rst), .frame_llrs(frame_3), .frame_valid(valid_3),
        .frame_ready(ready_3), .rx_busy(rx_busy), .databus_out(bus_3),
        .first_data(first_3), .data_valid(dvalid_3), .tx_done(done_3)
    );

    int total_checks  = 0;
    int passed_checks = 0;

    typedef struct {
        logic [31:0] data;
        logic        first;
    } vec_t;
    vec_t tbl[8];

    logic [255:0] ident;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: lane j of a full beat b holds LLR nv-(b+1)*4+j; the last beat holds LLR j for j<last_n.
    function automatic logic [31:0] model_beat(input logic [255:0] f, input int nv, input int b);
        int          nbeats = (nv - 1) / 4 + 1;
        int          last_n = (nv - 1) % 4 + 1;
        logic [31:0] r = '0;
        for (int j = 0; j < 4; j++) begin
            if (b == nbeats - 1) begin
                if (j < last_n) r[j*8 +: 8] = f[j*8 +: 8];
            end else begin
                r[j*8 +: 8] = f[(nv - (b + 1) * 4 + j)*8 +: 8];
            end
        end
        return r;
    endfunction

    task automatic wait_ready(input int bound);
        int n = 0;
        while (!frame_ready && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_ready", frame_ready, 1'b1);
    endtask

    task automatic applyStimulus(input logic [255:0] f, input int busy, input bit use_table,
                                 input bit inject, input int abort_beat);
        logic [31:0] exp_data;
        logic        exp_first;
        wait_ready(40);
        frame_llrs  = f[247:0];
        frame_valid = 1'b1;
        rx_busy     = (busy > 0);
        @(negedge clk);
        frame_valid = 1'b0;
        checkOutput("ready_low_after_accept", frame_ready, 1'b0);
        for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            checkOutput("no_valid_while_busy", data_valid, 1'b0);
        end
        rx_busy = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            exp_data  = use_table ? tbl[b].data  : model_beat(f, 31, b);
            exp_first = use_table ? tbl[b].first : (b == 0);
            checkOutput("beat_valid", data_valid, 1'b1);
            checkOutput("beat_data", databus_out, exp_data);
            checkOutput("beat_first", first_data, exp_first);
            checkOutput("ready_low_in_send", frame_ready, 1'b0);
            if (b == abort_beat) begin
                #2 rst = 1'b0;
                #1;
                checkOutput("rst_ready", frame_ready, 1'b0);
                checkOutput("rst_bus", databus_out, 32'h0);
                checkOutput("rst_first", first_data, 1'b0);
                checkOutput("rst_valid", data_valid, 1'b0);
                checkOutput("rst_done", tx_done, 1'b0);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                checkOutput("ready_after_release", frame_ready, 1'b1);
                return;
            end
            if (inject && b == 2) begin
                frame_llrs  = ~f[247:0];
                frame_valid = 1'b1;
            end
            @(negedge clk);
            frame_valid = 1'b0;
        end
        checkOutput("valid_falls", data_valid, 1'b0);
        checkOutput("done_pulse", tx_done, 1'b1);
        checkOutput("bus_cleared", databus_out, 32'h0);
        checkOutput("ready_low_in_done", frame_ready, 1'b0);
        @(negedge clk);
        checkOutput("done_one_cycle", tx_done, 1'b0);
        checkOutput("ready_back", frame_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] rnd;
        int           first_cycles[$];

        for (int k = 0; k < 32; k++) ident[k*8 +: 8] = 8'(k);
        tbl[0] = '{32'h1E1D1C1B, 1'b1};
        tbl[1] = '{32'h1A191817, 1'b0};
        tbl[2] = '{32'h16151413, 1'b0};
        tbl[3] = '{32'h1211100F, 1'b0};
        tbl[4] = '{32'h0E0D0C0B, 1'b0};
        tbl[5] = '{32'h0A090807, 1'b0};
        tbl[6] = '{32'h06050403, 1'b0};
        tbl[7] = '{32'h00020100, 1'b0};

        rst = 1'b0; rx_busy = 1'b0;
        frame_llrs = '0; frame_valid = 1'b0;
        frame_32 = '0; valid_32 = 1'b0;
        frame_3 = '0; valid_3 = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ready", frame_ready, 1'b0);
        checkOutput("reset_valid", data_valid, 1'b0);
        checkOutput("reset_first", first_data, 1'b0);
        checkOutput("reset_bus", databus_out, 32'h0);
        checkOutput("reset_done", tx_done, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("first_edge_ready", frame_ready, 1'b1);

        applyStimulus(ident, 0, 1'b1, 1'b0, -1);
        applyStimulus(ident, 10, 1'b0, 1'b0, -1);
        applyStimulus(ident, 0, 1'b0, 1'b1, -1);
        applyStimulus(ident, 0, 1'b0, 1'b0, 3);
        applyStimulus(ident, 0, 1'b1, 1'b0, -1);

        // Back-to-back frames with frame_valid held high: beat-0 spacing is N_BEATS+3.
        frame_llrs  = ident[247:0];
        frame_valid = 1'b1;
        rx_busy     = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (first_data) first_cycles.push_back(cyc);
        end
        frame_valid = 1'b0;
        checkOutput("b2b_first_count_ge2", (first_cycles.size() >= 2), 1'b1);
        if (first_cycles.size() >= 2)
            checkOutput("b2b_spacing", first_cycles[1] - first_cycles[0], 11);
        wait_ready(40);

        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 32; k++) rnd[k*8 +: 8] = 8'($urandom_range(0, 255));
            applyStimulus(rnd, int'($urandom_range(0, 3)), 1'b0, 1'b0, -1);
        end

        // N_V=32: every beat full.
        checkOutput("n32_ready", ready_32, 1'b1);
        frame_32 = ident;
        valid_32 = 1'b1;
        @(negedge clk);
        valid_32 = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            checkOutput("n32_valid", dvalid_32, 1'b1);
            checkOutput("n32_data", bus_32, model_beat(ident, 32, b));
            checkOutput("n32_first", first_32, (b == 0));
            if (b == 7) checkOutput("n32_last_beat", bus_32, 32'h03020100);
            @(negedge clk);
        end
        checkOutput("n32_valid_falls", dvalid_32, 1'b0);
        checkOutput("n32_done", done_32, 1'b1);

        // N_V=3: single partial beat that is also the first beat.
        checkOutput("n3_ready", ready_3, 1'b1);
        frame_3 = 24'h020100;
        valid_3 = 1'b1;
        @(negedge clk);
        valid_3 = 1'b0;
        @(negedge clk);
        checkOutput("n3_valid", dvalid_3, 1'b1);
        checkOutput("n3_data", bus_3, 32'h00020100);
        checkOutput("n3_first", first_3, 1'b1);
        @(negedge clk);
        checkOutput("n3_valid_falls", dvalid_3, 1'b0);
        checkOutput("n3_done", done_3, 1'b1);
        @(negedge clk);
        checkOutput("n3_ready_back", ready_3, 1'b1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
